muldiv_sequencer: RTL and testbench

//  Multicycle controller for the iterative mult/div unit behind the main opcode control.

---
 rtl/muldiv_sequencer.sv | 118 +++++++++++
 tb/tb_muldiv_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Multicycle controller for the iterative mult/div unit.
//                Optional macro MULDIV_EARLY_EXIT_EN ends mult once the
//                remaining multiplier is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [1:0]       OpSel,
    input  logic             DivisorZero,
    input  logic             MplierZero,
    output logic             Busy,
    output logic             LoadOps,
    output logic             StepMul,
    output logic             StepDiv,
    output logic             HiLoWrite,
    output logic             DivZeroExc,
    output logic             Done,
    output logic [CNT_W-1:0] IterCount
);

    localparam logic [1:0]       c_OP_MULT = 2'b00;
    localparam logic [1:0]       c_OP_RSVD = 2'b11;
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_EXC   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             w_is_mult;
    logic             w_early_exit;

    assign w_is_mult = (r_op == c_OP_MULT);

`ifdef MULDIV_EARLY_EXIT_EN
    // Remaining multiplier bits are all zero: further steps would only add zero.
    assign w_early_exit = (r_state == S_RUN) && w_is_mult && MplierZero;
`else
    logic w_unused_mplier;
    assign w_unused_mplier = MplierZero;
    assign w_early_exit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_op    <= c_OP_MULT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && Start && OpSel != c_OP_RSVD) begin
                r_op <= OpSel;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN && r_cnt != c_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start && OpSel != c_OP_RSVD) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!w_is_mult && DivisorZero) begin
                    w_state_next = S_EXC;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_early_exit || r_cnt == c_LAST) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: w_state_next = S_IDLE;
            S_EXC:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy       = (r_state != S_IDLE);
        LoadOps    = (r_state == S_LOAD);
        StepMul    = (r_state == S_RUN) && w_is_mult && !w_early_exit;
        StepDiv    = (r_state == S_RUN) && !w_is_mult;
        HiLoWrite  = (r_state == S_WRITE);
        DivZeroExc = (r_state == S_EXC);
        Done       = (r_state == S_WRITE) || (r_state == S_EXC);
    end

    assign IterCount = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer (table + random ops).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             Start;
    logic [1:0]       OpSel;
    logic             DivisorZero;
    logic             MplierZero;
    logic             Busy, LoadOps, StepMul, StepDiv, HiLoWrite, DivZeroExc, Done;
    logic [CNT_W-1:0] IterCount;

    muldiv_sequencer #(.ITER(ITER), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Start      (Start),
        .OpSel      (OpSel),
        .DivisorZero(DivisorZero),
        .MplierZero (MplierZero),
        .Busy       (Busy),
        .LoadOps    (LoadOps),
        .StepMul    (StepMul),
        .StepDiv    (StepDiv),
        .HiLoWrite  (HiLoWrite),
        .DivZeroExc (DivZeroExc),
        .Done       (Done),
        .IterCount  (IterCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int load;
        int nmul;
        int ndiv;
        int write;
        int nhlw;
        int exc;
        int busy;
        int done;
        int ndone;
        int iter_ok;
        int idle_after;
    } res_t;

    typedef struct {
        logic [1:0] op;
        logic       dz;
        int         mz_at;
        res_t       exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t mk(input int load, input int nmul, input int ndiv,
                                input int write, input int exc);
        res_t r;
        r.load = load;  r.nmul = nmul;  r.ndiv = ndiv;
        r.write = write; r.nhlw = (write != 0) ? 1 : 0;
        r.exc = exc;
        r.done = (write != 0) ? write : exc;
        r.busy = r.done;
        r.ndone = 1; r.iter_ok = 1; r.idle_after = 1;
        return r;
    endfunction

    // Transaction-level reference: counts and cycle numbers relative to Start.
    function automatic res_t model(input logic [1:0] op, input logic dz, input int mz_at);
        int steps;
        int wr;
        if (op != 2'b00 && dz) return mk(1, 0, 0, 0, 2);
        steps = ITER;
        wr    = ITER + 2;
`ifdef MULDIV_EARLY_EXIT_EN
        if (op == 2'b00 && mz_at >= 0 && mz_at < ITER) begin
            steps = mz_at;
            wr    = mz_at + 3;
        end
`endif
        return (op == 2'b00) ? mk(1, steps, 0, wr, 0) : mk(1, 0, steps, wr, 0);
    endfunction

    task automatic compare(input string tag, input res_t got, input res_t exp);
        chk({tag, ".load"},    got.load,       exp.load);
        chk({tag, ".stepmul"}, got.nmul,       exp.nmul);
        chk({tag, ".stepdiv"}, got.ndiv,       exp.ndiv);
        chk({tag, ".hlw_cyc"}, got.write,      exp.write);
        chk({tag, ".hlw_cnt"}, got.nhlw,       exp.nhlw);
        chk({tag, ".exc_cyc"}, got.exc,        exp.exc);
        chk({tag, ".busy"},    got.busy,       exp.busy);
        chk({tag, ".done_cyc"},got.done,       exp.done);
        chk({tag, ".done_cnt"},got.ndone,      exp.ndone);
        chk({tag, ".itercnt"}, got.iter_ok,    exp.iter_ok);
        chk({tag, ".idle"},    got.idle_after, exp.idle_after);
    endtask

    // Called after a negedge while idle; that cycle is t0 (Start accepted at its end).
    task automatic run_op(input logic [1:0] op, input logic dz, input int mz_at,
                          input bit noise, output res_t o);
        bit got_done = 0;
        o = '{default: 0};
        o.iter_ok = 1;
        Start = 1'b1; OpSel = op; DivisorZero = 1'($urandom); MplierZero = 1'b0;
        for (int k = 1; k <= ITER + 8 && !got_done; k++) begin
            @(posedge clk); #1;
            Start       = noise ? 1'($urandom) : 1'b0;
            OpSel       = noise ? 2'($urandom) : op;
            DivisorZero = (k == 1) ? dz : 1'($urandom);
            MplierZero  = (mz_at >= 0 && k >= mz_at + 2);
            @(negedge clk);
            if (LoadOps && o.load == 0) o.load = k;
            if (StepMul) o.nmul++;
            if (StepDiv) o.ndiv++;
            if (HiLoWrite) begin o.nhlw++; o.write = k; end
            if (DivZeroExc) o.exc = k;
            if (Busy) o.busy++;
            if (k >= 2 && Busy && !Done && IterCount != CNT_W'(k - 2)) o.iter_ok = 0;
            if (Done) begin o.ndone++; o.done = k; got_done = 1; end
        end
        chk("timeout", int'(got_done), 1);
        @(posedge clk); #1;
        Start = 1'b0; MplierZero = 1'b0;
        @(negedge clk);
        o.idle_after = int'(!Busy && !Done && !HiLoWrite && !DivZeroExc);
    endtask

    vec_t vecs[8];
    res_t got;
    res_t exp_r;

    initial begin
        vecs[0] = '{2'b00, 1'b0, -1, mk(1, 32, 0, 34, 0)};
        vecs[1] = '{2'b01, 1'b1, -1, mk(1, 0, 0, 0, 2)};
        vecs[2] = '{2'b10, 1'b0, -1, mk(1, 0, 32, 34, 0)};
        vecs[3] = '{2'b01, 1'b0, -1, mk(1, 0, 32, 34, 0)};
        vecs[4] = '{2'b00, 1'b1, -1, mk(1, 32, 0, 34, 0)};
        vecs[5] = '{2'b10, 1'b1, -1, mk(1, 0, 0, 0, 2)};
`ifdef MULDIV_EARLY_EXIT_EN
        vecs[6] = '{2'b00, 1'b0, 4, mk(1, 4, 0, 7, 0)};
`else
        vecs[6] = '{2'b00, 1'b0, 4, mk(1, 32, 0, 34, 0)};
`endif
        vecs[7] = '{2'b01, 1'b0, 4, mk(1, 0, 32, 34, 0)};

        reset_n = 1'b0; Start = 1'b0; OpSel = 2'b00; DivisorZero = 1'b0; MplierZero = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({Busy, LoadOps, StepMul, StepDiv, HiLoWrite, DivZeroExc, Done}), 0);
        chk("reset_cnt", int'(IterCount), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reserved opcode must never leave IDLE.
        begin
            int busy_seen = 0;
            Start = 1'b1; OpSel = 2'b11;
            repeat (4) begin
                @(negedge clk);
                if (Busy) busy_seen++;
            end
            Start = 1'b0;
            @(negedge clk);
            if (Busy) busy_seen++;
            chk("reserved_op_busy", busy_seen, 0);
        end

        // Table vectors, issued back-to-back; odd rows inject Start noise while busy.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].dz, vecs[i].mz_at, (i % 2) == 1, got);
            compare($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Asynchronous reset in the middle of a mult.
        Start = 1'b1; OpSel = 2'b00;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            Start = 1'b0;
            @(negedge clk);
        end
        chk("midrun_cnt", int'(IterCount), 15);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_outs", int'({Busy, LoadOps, StepMul, StepDiv, HiLoWrite, DivZeroExc, Done}), 0);
        chk("async_rst_cnt", int'(IterCount), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 1'b0, -1, 1'b0, got);
        compare("post_reset_mult", got, mk(1, 32, 0, 34, 0));

        // Randomized operations against the transaction-level model.
        for (int i = 0; i < 20; i++) begin
            logic [1:0] op;
            logic       dz;
            int         mz;
            op = 2'($urandom_range(0, 2));
            dz = ($urandom_range(0, 2) == 0);
            mz = $urandom_range(0, ITER + 4) - 1;
            exp_r = model(op, dz, mz);
            run_op(op, dz, mz, 1'($urandom), got);
            compare($sformatf("rnd%0d", i), got, exp_r);
            if ($urandom_range(0, 3) == 0) begin
                Start = 1'b1; OpSel = 2'b11;
                @(negedge clk);
                Start = 1'b0;
                @(negedge clk);
                chk($sformatf("rnd%0d.rsvd", i), int'(Busy), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
